serial_bus_ctrl: RTL and testbench
==================================

# serial_bus_ctrl

Sequencing controller and arbiter for the shared 8-bit RAM1 data bus. Two requesters share the bus: a CPU-side RAM1 port and a UART byte port serviced through the CPLD. The block grants the bus round-robin and generates the RAM1 enables and the CPLD `rdn`/`wrn` strobes. It also runs the `tbre`/`tsre`/`dataReady` handshakes and returns one-cycle acknowledges with read data. It sits between the CPU memory stage and the board-level RAM1/CPLD pins and replaces direct strobe wiring to those pins.

## Interface
- `ADDR_W`, 18: RAM1 address width.
- `MEM_CYC`, 2: RAM1 strobe width in cycles (≥1).
- `STROBE_CYC`, 2: `rdn`/`wrn` low width in cycles (≥1).

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_req`, `mem_we`  in  1  RAM1 request / 1 = write; held with arguments until `mem_ack`.
- `mem_addr`  in  ADDR_W  RAM1 address.
- `mem_wdata`  in  8  RAM1 write byte.
- `mem_ack`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  8  RAM1 read byte; valid with `mem_ack`, held until next read.
- `uart_req`, `uart_we`  in  1  UART request / 1 = send byte; held until `uart_ack`.
- `uart_wdata`  in  8  byte to send.
- `uart_ack`  out  1  one-cycle completion pulse.
- `uart_rdata`  out  8  received byte; valid with `uart_ack`.
- `tbre`, `tsre`, `dataReady`  in  1  CPLD status; asynchronous to `clk`.
- `ram1Data`  inout  8  shared bus.
- `ram1Addr`  out  ADDR_W  RAM1 address.
- `ram1En`, `ram1Oe`, `ram1We`  out  1  RAM1 controls, active low.
- `rdn`, `wrn`  out  1  CPLD read/write strobes, active low.
- `status`  out  4  {busy, last_grant_uart, dataReady_s, tbre_s & tsre_s}.

## Operation
- `tbre`, `tsre` and `dataReady` each pass through a 2-flop synchronizer (`_s` suffix); the FSM uses only the synchronized values.
- All control outputs are registered; `ram1Data` output-enable comes from a registered `drive` flag.
- Arbitration happens only in IDLE.
  - One request pending: that requester is granted.
  - Both pending: the requester not granted last is granted.
  - `last_grant` resets to UART, so the memory port wins the first tie.
- Memory path, IDLE → M_SETUP → M_STROBE → DONE:
  - M_SETUP (1 cycle): `ram1Addr` loaded, `ram1En`=0, `ram1Oe`=`ram1We`=1; `drive`=`mem_we`.
  - M_STROBE (MEM_CYC cycles): `ram1We`=0 for a write or `ram1Oe`=0 for a read. A read samples `ram1Data` into `mem_rdata` on the last strobe edge.
- UART write path, IDLE → U_WSETUP → U_WSTROBE → U_WHOLD → U_WTBRE → U_WTSRE → DONE:
  - U_WSETUP (1 cycle): `drive`=1 with `uart_wdata`, `wrn`=1.
  - U_WSTROBE (STROBE_CYC cycles): `wrn`=0.
  - U_WHOLD (3 cycles): `wrn`=1; `drive` stays 1 in the first cycle only. This covers bus hold time plus synchronizer latency.
  - U_WTBRE waits for `tbre_s`=1; U_WTSRE waits for `tsre_s`=1.
- UART read path, IDLE → U_RWAIT → U_RSTROBE → U_RRECOV → DONE:
  - U_RWAIT waits for `dataReady_s`=1.
  - U_RSTROBE (STROBE_CYC cycles): `rdn`=0, `drive`=0; `uart_rdata` is sampled on the last edge.
  - U_RRECOV (2 cycles): `rdn`=1, so the synchronized `dataReady` can clear before the next read.
- During every UART state `ram1En`=`ram1Oe`=`ram1We`=1, keeping RAM1 off the bus.
- DONE (1 cycle): pulses the granted ack, updates `last_grant`, then returns to IDLE. Requests are ignored in DONE; a requester drops `req` at the edge that samples its ack.
- `busy`=1 in every state except IDLE.

## Timing
- Reset (asynchronous, immediate, even mid-transfer):
  - `rdn`=`wrn`=`ram1En`=`ram1Oe`=`ram1We`=1, `drive`=0 (bus Z).
  - Acks 0, `mem_rdata`=`uart_rdata`=0, `ram1Addr`=0.
  - Synchronizers 0, state IDLE.
- Memory latency: request seen in IDLE at edge 0 → `mem_ack` high in cycle 2+MEM_CYC (4 at default).
- UART write: `wrn` low exactly STROBE_CYC cycles. Data is driven from 1 cycle before `wrn` falls until 1 cycle after it rises. Ack arrives no sooner than cycle 1+STROBE_CYC+3+2+1 (9 at default).
- UART read: ack exactly 2+STROBE_CYC+1 cycles after `dataReady_s` is first seen high in U_RWAIT.
- Mutual exclusion: `rdn`/`wrn` low never overlaps `ram1En`=0. `drive`=1 never overlaps `ram1Oe`=0 or `rdn`=0.
- No timeout: the wait states hold indefinitely, with `busy`=1.

## Test plan
- Reset: assert `rst`=0 for 3 cycles with random inputs → all strobes 1, bus Z, acks 0, `status`=4'b0000.
- Memory write then read: write addr 0x00123 with data 0xA5, then read addr 0x00123 with a bus model returning 0xA5 → `ram1We` low 2 cycles, `mem_ack` at cycle 4 of each access, `mem_rdata`=0xA5.
- UART send 0x3C: model holds `tbre` low 10 cycles, then `tsre` low 5 more → `wrn` low 2 cycles with bus=0x3C; `uart_ack` arrives only after both are high; no RAM enable at any time.
- UART receive: raise `dataReady` after 20 cycles with bus driving 0x5A while `rdn`=0 → `rdn` low 2 cycles, `uart_rdata`=0x5A, ack 5 cycles after `dataReady_s` is seen.
- Simultaneous `mem_req` and `uart_req` held from reset → grant order mem, uart, mem, uart; no strobe overlap.
- Reset mid-`wrn` pulse → `wrn` rises asynchronously, bus Z, state IDLE; next request completes normally.

Source files
------------

// File: rtl/serial_bus_ctrl.sv
// Round-robin arbiter and strobe sequencer for the shared RAM1 data bus.
// The CPU RAM1 port and the CPLD UART byte port take turns; every pin-level control is registered.
module serial_bus_ctrl #(
  parameter int ADDR_W     = 18,
  parameter int MEM_CYC    = 2,
  parameter int STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic              mem_ack,
  output logic [7:0]        mem_rdata,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [7:0]        uart_wdata,
  output logic              uart_ack,
  output logic [7:0]        uart_rdata,
  input  logic              tbre,
  input  logic              tsre,
  input  logic              dataReady,
  inout  wire  [7:0]        ram1Data,
  output logic [ADDR_W-1:0] ram1Addr,
  output logic              ram1En,
  output logic              ram1Oe,
  output logic              ram1We,
  output logic              rdn,
  output logic              wrn,
  output logic [3:0]        status
);

  typedef enum logic [3:0] {
    IDLE, M_SETUP, M_STROBE,
    U_WSETUP, U_WSTROBE, U_WHOLD, U_WTBRE, U_WTSRE,
    U_RWAIT, U_RSTROBE, U_RRECOV, DONE
  } state_t;

  state_t      state, next_state;
  logic [7:0]  cnt;
  logic [2:0]  sync1, sync2;
  logic        tbre_s, tsre_s, dready_s;
  logic        pick_mem, pick_uart;
  logic        grant_uart, op_we, last_uart, last_uart_stat, busy, drive;
  logic [7:0]  dout;
  logic        en_n, oe_n, we_n, rdn_n, wrn_n, drive_n, mem_ack_n, uart_ack_n, busy_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {tbre, tsre, dataReady};
      sync2 <= sync1;
    end
  end

  assign tbre_s   = sync2[2];
  assign tsre_s   = sync2[1];
  assign dready_s = sync2[0];

  // On a tie the requester that was not served last wins; last_uart starts set so memory wins first.
  assign pick_mem  = mem_req && (!uart_req || last_uart);
  assign pick_uart = uart_req && !pick_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? 8'd0 : cnt + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_mem)       next_state = M_SETUP;
        else if (pick_uart) next_state = uart_we ? U_WSETUP : U_RWAIT;
      end
      M_SETUP:   next_state = M_STROBE;
      M_STROBE:  if (cnt == 8'(MEM_CYC - 1)) next_state = DONE;
      U_WSETUP:  next_state = U_WSTROBE;
      U_WSTROBE: if (cnt == 8'(STROBE_CYC - 1)) next_state = U_WHOLD;
      U_WHOLD:   if (cnt == 8'd2) next_state = U_WTBRE;
      U_WTBRE:   if (tbre_s) next_state = U_WTSRE;
      U_WTSRE:   if (tsre_s) next_state = DONE;
      U_RWAIT:   if (dready_s) next_state = U_RSTROBE;
      U_RSTROBE: if (cnt == 8'(STROBE_CYC - 1)) next_state = U_RRECOV;
      U_RRECOV:  if (cnt == 8'd1) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered pins line up with the state they belong to.
  always_comb begin
    en_n       = 1'b1;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    rdn_n      = 1'b1;
    wrn_n      = 1'b1;
    drive_n    = 1'b0;
    mem_ack_n  = 1'b0;
    uart_ack_n = 1'b0;
    busy_n     = (next_state != IDLE);
    case (next_state)
      M_SETUP: begin
        en_n    = 1'b0;
        drive_n = mem_we;
      end
      M_STROBE: begin
        en_n    = 1'b0;
        we_n    = !op_we;
        oe_n    = op_we;
        drive_n = op_we;
      end
      U_WSETUP:  drive_n = 1'b1;
      U_WSTROBE: begin
        wrn_n   = 1'b0;
        drive_n = 1'b1;
      end
      U_WHOLD:   drive_n = (state != U_WHOLD);
      U_RSTROBE: rdn_n = 1'b0;
      DONE: begin
        mem_ack_n  = !grant_uart;
        uart_ack_n = grant_uart;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram1En         <= 1'b1;
      ram1Oe         <= 1'b1;
      ram1We         <= 1'b1;
      rdn            <= 1'b1;
      wrn            <= 1'b1;
      drive          <= 1'b0;
      mem_ack        <= 1'b0;
      uart_ack       <= 1'b0;
      busy           <= 1'b0;
      mem_rdata      <= '0;
      uart_rdata     <= '0;
      ram1Addr       <= '0;
      grant_uart     <= 1'b0;
      op_we          <= 1'b0;
      last_uart      <= 1'b1;
      last_uart_stat <= 1'b0;
    end else begin
      ram1En   <= en_n;
      ram1Oe   <= oe_n;
      ram1We   <= we_n;
      rdn      <= rdn_n;
      wrn      <= wrn_n;
      drive    <= drive_n;
      mem_ack  <= mem_ack_n;
      uart_ack <= uart_ack_n;
      busy     <= busy_n;
      if (state == IDLE && next_state != IDLE) grant_uart <= (next_state != M_SETUP);
      if (next_state == M_SETUP) begin
        op_we    <= mem_we;
        ram1Addr <= mem_addr;
      end
      if (state == M_STROBE && next_state == DONE && !op_we) mem_rdata <= ram1Data;
      if (state == U_RSTROBE && next_state == U_RRECOV) uart_rdata <= ram1Data;
      // The status copy reads 0 until a transfer has actually completed.
      if (state == DONE) begin
        last_uart      <= grant_uart;
        last_uart_stat <= grant_uart;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (next_state == M_SETUP)       dout <= mem_wdata;
    else if (next_state == U_WSETUP) dout <= uart_wdata;
  end

  assign ram1Data = drive ? dout : 8'hzz;
  assign status   = {busy, last_uart_stat, dready_s, tbre_s & tsre_s};

endmodule

// File: tb/tb_serial_bus_ctrl.sv
// Scoreboard bench for serial_bus_ctrl: directed vectors push expected acks, a monitor pops on each ack.
// A RAM1/CPLD bus model answers reads; a strobe monitor checks pulse widths and exclusion.
module tb_serial_bus_ctrl;
  localparam int ADDR_W = 18;
  localparam int MEM_CYC = 2;
  localparam int STROBE_CYC = 2;

  logic              clk, rst;
  logic              mem_req, mem_we, uart_req, uart_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, uart_wdata, mem_rdata, uart_rdata;
  logic              mem_ack, uart_ack;
  logic              tbre, tsre, dataReady;
  wire  [7:0]        ram1Data;
  logic [ADDR_W-1:0] ram1Addr;
  logic              ram1En, ram1Oe, ram1We, rdn, wrn;
  logic [3:0]        status;

  serial_bus_ctrl #(.ADDR_W(ADDR_W), .MEM_CYC(MEM_CYC), .STROBE_CYC(STROBE_CYC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .uart_req(uart_req), .uart_we(uart_we), .uart_wdata(uart_wdata),
    .uart_ack(uart_ack), .uart_rdata(uart_rdata),
    .tbre(tbre), .tsre(tsre), .dataReady(dataReady),
    .ram1Data(ram1Data), .ram1Addr(ram1Addr),
    .ram1En(ram1En), .ram1Oe(ram1Oe), .ram1We(ram1We),
    .rdn(rdn), .wrn(wrn), .status(status)
  );

  typedef struct {
    bit         uart;
    bit         chk_data;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   viol = 0;
  int   en_low_cnt = 0;
  logic [7:0] exp_wbyte = 8'h00;
  logic [7:0] rx_byte = 8'h5A;
  logic [7:0] mm [logic [ADDR_W-1:0]];
  logic [7:0] tb_dout = 8'h00;
  logic       tb_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tb_oe    = (!ram1En && !ram1Oe) || !rdn;
  assign ram1Data = tb_oe ? tb_dout : 8'hzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (rst && (mem_ack || uart_ack)) begin
      if (mem_ack && uart_ack) check("dual_ack", 1, 0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", {31'd0, uart_ack}, {31'd0, mon_e.uart});
        check("ack_cycle", cyc, mon_e.cyc);
        if (mon_e.chk_data) check("rdata", {24'd0, uart_ack ? uart_rdata : mem_rdata}, {24'd0, mon_e.data});
      end
    end
  end

  // Bus model and strobe monitor.
  initial begin : strobe_mon
    int wlow, rlow, welow, oelow;
    wlow = 0; rlow = 0; welow = 0; oelow = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wlow = 0; rlow = 0; welow = 0; oelow = 0;
      end else begin
        if (!ram1En && !ram1We) mm[ram1Addr] = ram1Data;
        tb_dout = !rdn ? rx_byte : (mm.exists(ram1Addr) ? mm[ram1Addr] : 8'hEE);
        if (!wrn) begin
          wlow++;
          check("uart_tx_bus", {24'd0, ram1Data}, {24'd0, exp_wbyte});
        end else if (wlow > 0) begin
          check("wrn_width", wlow, STROBE_CYC);
          wlow = 0;
        end
        if (!rdn) rlow++;
        else if (rlow > 0) begin check("rdn_width", rlow, STROBE_CYC); rlow = 0; end
        if (!ram1We) welow++;
        else if (welow > 0) begin check("we_width", welow, MEM_CYC); welow = 0; end
        if (!ram1Oe) oelow++;
        else if (oelow > 0) begin check("oe_width", oelow, MEM_CYC); oelow = 0; end
        if (!ram1En) en_low_cnt++;
        if ((!rdn || !wrn) && !ram1En) viol++;
        if (!rdn && !wrn) viol++;
        if (!ram1Oe && !ram1We) viol++;
      end
    end
  end

  task automatic wait_ack(input bit uart, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = uart ? uart_ack : mem_ack;
    end
    check(uart ? "uart_ack_timeout" : "mem_ack_timeout", {31'd0, got}, 1);
  endtask

  task automatic mem_access(input bit we, input logic [ADDR_W-1:0] addr, input logic [7:0] wd,
                            input logic [7:0] exp_rd);
    exp_t e;
    @(negedge clk);
    mem_we = we; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
    e.uart = 1'b0; e.chk_data = !we; e.data = exp_rd; e.cyc = cyc + 2 + MEM_CYC;
    sb.push_back(e);
    wait_ack(1'b0, 20);
    mem_req = 1'b0;
  endtask

  initial begin : stim
    exp_t e;
    int   c, acks;
    rst = 1'b1;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = 0;
    uart_req = 0; uart_we = 0; uart_wdata = 0;
    tbre = 0; tsre = 0; dataReady = 0;
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      mem_req = 1'($urandom); mem_we = 1'($urandom); mem_addr = ADDR_W'($urandom);
      uart_req = 1'($urandom); uart_we = 1'($urandom);
      tbre = 1'($urandom); tsre = 1'($urandom); dataReady = 1'($urandom);
    end
    #1;
    check("rst_strobes", {27'd0, rdn, wrn, ram1En, ram1Oe, ram1We}, 32'h1F);
    check("rst_acks", {30'd0, mem_ack, uart_ack}, 0);
    check("rst_status", {28'd0, status}, 0);
    check("rst_rdata", {16'd0, mem_rdata, uart_rdata}, 0);
    check("rst_addr", {14'd0, ram1Addr}, 0);
    mem_req = 0; mem_we = 0; uart_req = 0; uart_we = 0;
    tbre = 1; tsre = 1; dataReady = 0;
    @(negedge clk);
    rst = 1'b1;

    // Tie from reset: expect mem, uart, mem, uart with fixed latencies.
    @(negedge clk);
    mem_we = 1; mem_addr = 18'h00200; mem_wdata = 8'h11; mem_req = 1;
    uart_we = 1; uart_wdata = 8'h77; exp_wbyte = 8'h77; uart_req = 1;
    c = cyc;
    e.chk_data = 0; e.data = 0;
    e.uart = 0; e.cyc = c + 4;  sb.push_back(e);
    e.uart = 1; e.cyc = c + 14; sb.push_back(e);
    e.uart = 0; e.cyc = c + 19; sb.push_back(e);
    e.uart = 1; e.cyc = c + 29; sb.push_back(e);
    acks = 0;
    for (int i = 0; i < 80 && acks < 4; i++) begin
      @(negedge clk);
      if (mem_ack || uart_ack) acks++;
    end
    mem_req = 0; uart_req = 0;
    check("tie_ack_count", acks, 4);

    mem_access(1'b1, 18'h00123, 8'hA5, 8'h00);
    mem_access(1'b0, 18'h00123, 8'h00, 8'hA5);

    // UART send with scripted tbre/tsre.
    en_low_cnt = 0;
    @(negedge clk);
    uart_we = 1; uart_wdata = 8'h3C; exp_wbyte = 8'h3C; uart_req = 1;
    c = cyc;
    e.uart = 1; e.chk_data = 0; e.data = 0; e.cyc = c + 20; sb.push_back(e);
    repeat (2) @(negedge clk);
    tbre = 0; tsre = 0;
    repeat (10) @(negedge clk);
    tbre = 1;
    repeat (5) @(negedge clk);
    tsre = 1;
    wait_ack(1'b1, 20);
    uart_req = 0;
    check("uart_tx_ram_enable", en_low_cnt, 0);

    // UART receive.
    @(negedge clk);
    uart_we = 0; uart_req = 1; dataReady = 0; rx_byte = 8'h5A;
    c = cyc;
    e.uart = 1; e.chk_data = 1; e.data = 8'h5A; e.cyc = c + 27; sb.push_back(e);
    repeat (20) @(negedge clk);
    dataReady = 1;
    wait_ack(1'b1, 30);
    uart_req = 0; dataReady = 0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a wrn pulse.
    @(negedge clk);
    uart_we = 1; uart_wdata = 8'h3C; exp_wbyte = 8'h3C; uart_req = 1;
    repeat (2) @(negedge clk);
    check("wrn_low_pre_rst", {31'd0, wrn}, 0);
    #2 rst = 1'b0;
    #1;
    check("midrst_strobes", {27'd0, rdn, wrn, ram1En, ram1Oe, ram1We}, 32'h1F);
    check("midrst_status", {28'd0, status}, 0);
    check("midrst_acks", {30'd0, mem_ack, uart_ack}, 0);
    uart_req = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_access(1'b1, 18'h3FFFF, 8'hC3, 8'h00);
    mem_access(1'b0, 18'h3FFFF, 8'h00, 8'hC3);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("strobe_overlap", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
